// File: rtl/inst_mem_pipe.sv
// inst_mem_pipe: instruction store with a synchronous, pipelined read and a
// valid/ready fetch interface. It sits between the PC/fetch unit and decode.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req_valid/req_ready      fetch request handshake, req_addr = word address
//   rsp_valid/rsp_ready      response handshake; rsp_data = instruction word,
//                            rsp_err = request address was >= DEPTH
//   flush                    drop every accepted, undelivered fetch (redirect)
//   ld_en/ld_addr/ld_data    program-load write port, independent of fetches
//
// The array is read at the acceptance edge. RD_LAT=2 inserts one more
// register stage. A CAP-entry output FIFO absorbs decode backpressure, and the
// outstanding counter (pipe + FIFO) throttles req_ready so it never overflows.
module inst_mem_pipe #(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 10,
  parameter int    DEPTH     = 1024,
  parameter int    RD_LAT    = 1,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int CAP   = RD_LAT + 1;
  localparam int CNT_W = $clog2(CAP + 1);
  localparam int PTR_W = $clog2(CAP);
  localparam logic [ADDR_W:0]  DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CAP_X   = CNT_W'(CAP);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_X);
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(CAP - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic accept;
  logic pop;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign req_ready = !rst && !flush && (outstanding < CAP_X);
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  // Load port: the write lands at the edge, so a read at the same edge sees the
  // old word (read-before-write).
  always_ff @(posedge clk) begin
    if (ld_en && in_range(ld_addr)) mem[ld_addr] <= ld_data;
  end

  // ---- stage p0: array read at the acceptance edge ----
  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;
  logic              err_p0;

  always_ff @(posedge clk) begin
    if (rst || flush) vld_p0 <= 1'b0;
    else              vld_p0 <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      data_p0 <= in_range(req_addr) ? mem[req_addr] : '0;
      err_p0  <= !in_range(req_addr);
    end
  end

  logic              vld_out;
  logic [DATA_W-1:0] data_out;
  logic              err_out;

  generate
    if (RD_LAT == 2) begin : g_lat2
      // ---- stage p1: extra register stage for RD_LAT=2 ----
      logic              vld_p1;
      logic [DATA_W-1:0] data_p1;
      logic              err_p1;

      always_ff @(posedge clk) begin
        if (rst || flush) vld_p1 <= 1'b0;
        else              vld_p1 <= vld_p0;
      end

      always_ff @(posedge clk) begin
        if (vld_p0) begin
          data_p1 <= data_p0;
          err_p1  <= err_p0;
        end
      end

      assign vld_out  = vld_p1;
      assign data_out = data_p1;
      assign err_out  = err_p1;
    end else begin : g_lat1
      assign vld_out  = vld_p0;
      assign data_out = data_p0;
      assign err_out  = err_p0;
    end
  endgenerate

  // ---- output buffer: CAP-entry FIFO feeding decode ----
  logic [DATA_W-1:0] fifo_data [CAP];
  logic              fifo_err  [CAP];

  // A write during a flush edge is harmless: the pointers are cleared.
  always_ff @(posedge clk) begin
    if (vld_out) begin
      fifo_data[wr_ptr] <= data_out;
      fifo_err[wr_ptr]  <= err_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
    end else begin
      if (vld_out) wr_ptr <= next_ptr(wr_ptr);
      if (pop)     rd_ptr <= next_ptr(rd_ptr);
      case ({vld_out, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Data storage is never reset; gating with rsp_valid gives zeros when empty.
  assign rsp_valid = (count != '0);
  assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
  assign rsp_err   = rsp_valid ? fifo_err[rd_ptr]  : 1'b0;

endmodule
